// File: rtl/fetch_cache_pkg.sv
// Shared types and helpers for the direct-mapped instruction fetch cache.
package fetch_cache_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StMissReq  = 2'd1,
    StFillWait = 2'd2,
    StRespond  = 2'd3
  } state_e;

  function automatic int unsigned tag_bits(int unsigned addr_bits, int unsigned num_lines);
    return addr_bits - $clog2(num_lines);
  endfunction

endpackage

// File: rtl/fetch_cache_array.sv
// Valid/tag/data storage: combinational lookup, synchronous fill, flush clears valid bits.
module fetch_cache_array import fetch_cache_pkg::*; #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned NUM_LINES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] lookup_address,
  output logic                 hit,
  output logic [DATA_BITS-1:0] lookup_data,
  input  logic                 fill,
  input  logic [ADDR_BITS-1:0] fill_address,
  input  logic [DATA_BITS-1:0] fill_data,
  input  logic                 flush
);

  localparam int unsigned IdxBits = $clog2(NUM_LINES);
  localparam int unsigned TagBits = tag_bits(ADDR_BITS, NUM_LINES);

  logic [NUM_LINES-1:0] valid;
  logic [TagBits-1:0]   tag_mem  [NUM_LINES];
  logic [DATA_BITS-1:0] data_mem [NUM_LINES];

  logic [IdxBits-1:0] lookup_idx;
  logic [IdxBits-1:0] fill_idx;

  assign lookup_idx  = lookup_address[IdxBits-1:0];
  assign fill_idx    = fill_address[IdxBits-1:0];
  assign hit         = valid[lookup_idx] &&
                       (tag_mem[lookup_idx] == lookup_address[ADDR_BITS-1:IdxBits]);
  assign lookup_data = data_mem[lookup_idx];

  // Flush takes priority so a line filled on the flush edge ends up invalid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (fill) begin
      valid[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[fill_idx]  <= fill_address[ADDR_BITS-1:IdxBits];
      data_mem[fill_idx] <= fill_data;
    end
  end

endmodule

// File: rtl/fetch_cache.sv
// Direct-mapped read-only fetch cache; four-phase handshakes on both sides.
// Define FETCH_CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module fetch_cache import fetch_cache_pkg::*; #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned NUM_LINES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 read_valid,
  input  logic [ADDR_BITS-1:0] read_address,
  output logic                 read_ready,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 mem_read_valid,
  output logic [ADDR_BITS-1:0] mem_read_address,
  input  logic                 mem_read_ready,
  input  logic [DATA_BITS-1:0] mem_read_data,
  input  logic                 flush
`ifdef FETCH_CACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  state_e               state;
  logic                 hit;
  logic [DATA_BITS-1:0] hit_data;
  logic                 fill;

  assign fill = (state == StMissReq) && mem_read_ready;

  fetch_cache_array #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .NUM_LINES (NUM_LINES)
  ) u_array (
    .clk            (clk),
    .reset          (reset),
    .lookup_address (read_address),
    .hit            (hit),
    .lookup_data    (hit_data),
    .fill           (fill),
    .fill_address   (mem_read_address),
    .fill_data      (mem_read_data),
    .flush          (flush)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= StIdle;
      read_ready       <= 1'b0;
      read_data        <= '0;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (read_valid) begin
            if (hit) begin
              read_ready <= 1'b1;
              read_data  <= hit_data;
              state      <= StRespond;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= read_address;
              state            <= StMissReq;
            end
          end
        end
        StMissReq: begin
          if (mem_read_ready) begin
            mem_read_valid <= 1'b0;
            read_data      <= mem_read_data;
            state          <= StFillWait;
          end
        end
        // Hold off until the controller releases its strobe.
        StFillWait: begin
          if (!mem_read_ready) begin
            read_ready <= 1'b1;
            state      <= StRespond;
          end
        end
        StRespond: begin
          if (!read_valid) begin
            read_ready <= 1'b0;
            state      <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

`ifdef FETCH_CACHE_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (state == StIdle && read_valid) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      end else begin
        if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_cache.sv
// Self-checking bench for fetch_cache: vector table, hand sequences, random vs reference model.
module tb_fetch_cache;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 16;
  localparam int unsigned NL = 16;

  logic          clk;
  logic          reset;
  logic          read_valid;
  logic [AW-1:0] read_address;
  logic          read_ready;
  logic [DW-1:0] read_data;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DW-1:0] mem_read_data;
  logic          flush;
`ifdef FETCH_CACHE_STATS_EN
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;
`endif

  fetch_cache #(
    .ADDR_BITS (AW),
    .DATA_BITS (DW),
    .NUM_LINES (NL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .read_valid       (read_valid),
    .read_address     (read_address),
    .read_ready       (read_ready),
    .read_data        (read_data),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .flush            (flush)
`ifdef FETCH_CACHE_STATS_EN
    ,
    .hit_count        (hit_count),
    .miss_count       (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int fails;

  // Reference model: backing memory plus which full address each line holds (-1 = none).
  logic [DW-1:0] mem [256];
  int            resident [NL];
  int            m_hits;
  int            m_misses;

  typedef struct {
    logic [7:0]  addr;
    bit          flush_before;
    bit          flush_fill;
    int          delay;
    bit          exp_hit;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(NL); i++) resident[i] = -1;
  endtask

  task automatic model_access(input logic [7:0] a, input bit fb, input bit ff,
                              output bit exp_hit);
    int idx;
    idx = int'(a) % int'(NL);
    if (fb) model_clear();
    exp_hit = (resident[idx] == int'(a));
    if (exp_hit) begin
      m_hits++;
    end else begin
      m_misses++;
      resident[idx] = int'(a);
      if (ff) model_clear();
    end
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Acts as both fetcher and controller for one complete transaction.
  task automatic do_read(input logic [7:0] addr, input int delay, input bit flush_fill,
                         input int hold, input bit flush_resp,
                         output bit saw_mem, output logic [15:0] data);
    int         cyc;
    int         mem_lat;
    int         fall_cyc;
    int         wait_cnt;
    bit         got;
    logic [7:0] maddr;
    saw_mem  = 1'b0;
    got      = 1'b0;
    mem_lat  = 0;
    fall_cyc = -100;
    wait_cnt = 0;
    maddr    = '0;
    data     = '0;
    cyc      = 0;
    read_valid   = 1'b1;
    read_address = addr;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      if (mem_read_valid && !saw_mem) begin
        saw_mem  = 1'b1;
        mem_lat  = cyc;
        maddr    = mem_read_address;
        wait_cnt = delay;
      end
      if (saw_mem && mem_read_valid && !mem_read_ready) begin
        if (wait_cnt == 0) begin
          mem_read_ready = 1'b1;
          mem_read_data  = mem[maddr];
          if (flush_fill) flush = 1'b1;
        end else begin
          wait_cnt--;
        end
      end else if (mem_read_ready && !mem_read_valid) begin
        mem_read_ready = 1'b0;
        fall_cyc       = cyc;
      end
      if (read_ready) begin
        got  = 1'b1;
        data = read_data;
      end
    end
    flush = 1'b0;
    check("response_seen", 32'(got), 32'd1);
    if (got) begin
      if (saw_mem) begin
        check("miss_req_latency", mem_lat, 1);
        check("miss_req_address", 32'(maddr), 32'(addr));
        check("ready_after_strobe_fall", cyc - fall_cyc, 1);
      end else begin
        check("hit_latency", cyc, 1);
      end
      for (int h = 1; h <= hold; h++) begin
        flush = (flush_resp && h == 2);
        @(negedge clk);
        check("hold_ready", 32'(read_ready), 32'd1);
        check("hold_data", 32'(read_data), 32'(data));
      end
      flush = 1'b0;
    end
    read_valid = 1'b0;
    @(negedge clk);
    check("ready_drop", 32'(read_ready), 32'd0);
    mem_read_ready = 1'b0;
  endtask

  initial begin
    bit          saw;
    bit          eh;
    logic [15:0] d;
    logic [7:0]  a;
    int          dl;
    bit          fb;
    bit          ff;

    tests = 0;
    fails = 0;
    m_hits = 0;
    m_misses = 0;
    model_clear();
    for (int i = 0; i < 256; i++) mem[i] = 16'hA500 | 16'(i);
    mem[8'h23] = 16'hBEEF;

    vecs[0]  = '{8'h23, 1'b0, 1'b0, 3, 1'b0, 16'hBEEF};
    vecs[1]  = '{8'h23, 1'b0, 1'b0, 0, 1'b1, 16'hBEEF};
    vecs[2]  = '{8'h03, 1'b0, 1'b0, 1, 1'b0, 16'hA503};
    vecs[3]  = '{8'h13, 1'b0, 1'b0, 0, 1'b0, 16'hA513};
    vecs[4]  = '{8'h03, 1'b0, 1'b0, 2, 1'b0, 16'hA503};
    vecs[5]  = '{8'h05, 1'b0, 1'b0, 1, 1'b0, 16'hA505};
    vecs[6]  = '{8'h05, 1'b0, 1'b0, 0, 1'b1, 16'hA505};
    vecs[7]  = '{8'h05, 1'b1, 1'b0, 2, 1'b0, 16'hA505};
    vecs[8]  = '{8'h07, 1'b0, 1'b1, 1, 1'b0, 16'hA507};
    vecs[9]  = '{8'h07, 1'b0, 1'b0, 0, 1'b0, 16'hA507};
    vecs[10] = '{8'h07, 1'b0, 1'b0, 3, 1'b1, 16'hA507};
    vecs[11] = '{8'h13, 1'b0, 1'b0, 0, 1'b0, 16'hA513};

    reset          = 1'b1;
    read_valid     = 1'b0;
    read_address   = '0;
    mem_read_ready = 1'b0;
    mem_read_data  = '0;
    flush          = 1'b0;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_read_ready", 32'(read_ready), 32'd0);
    check("rst_read_data", 32'(read_data), 32'd0);
    check("rst_mem_valid", 32'(mem_read_valid), 32'd0);
    check("rst_mem_address", 32'(mem_read_address), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].flush_before) pulse_flush();
      do_read(vecs[i].addr, vecs[i].delay, vecs[i].flush_fill, 0, 1'b0, saw, d);
      model_access(vecs[i].addr, vecs[i].flush_before, vecs[i].flush_fill, eh);
      check($sformatf("vec%0d_hit", i), 32'(!saw), 32'(vecs[i].exp_hit));
      check($sformatf("vec%0d_data", i), 32'(d), 32'(vecs[i].exp_data));
    end

    // Reset asserted between edges while a miss is outstanding.
    pulse_flush();
    read_valid   = 1'b1;
    read_address = 8'h40;
    @(negedge clk);
    check("pre_rst_mem_valid", 32'(mem_read_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_mem_valid", 32'(mem_read_valid), 32'd0);
    check("async_rst_read_ready", 32'(read_ready), 32'd0);
    read_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    m_hits = 0;
    m_misses = 0;
    @(negedge clk);

    // Post-reset miss, long fetcher hold, and a flush during the response.
    model_access(8'h23, 1'b0, 1'b0, eh);
    do_read(8'h23, 3, 1'b0, 5, 1'b1, saw, d);
    model_clear();
    check("post_rst_miss", 32'(saw), 32'd1);
    check("post_rst_data", 32'(d), 32'hBEEF);
    model_access(8'h23, 1'b0, 1'b0, eh);
    do_read(8'h23, 0, 1'b0, 0, 1'b0, saw, d);
    check("flush_in_respond_miss", 32'(saw), 32'd1);

    for (int i = 0; i < 300; i++) mem[i % 256] = 16'($urandom);
    pulse_flush();
    model_clear();
    for (int n = 0; n < 120; n++) begin
      a  = 8'($urandom_range(0, 47));
      dl = int'($urandom_range(0, 3));
      fb = ($urandom_range(0, 7) == 0);
      ff = ($urandom_range(0, 7) == 0);
      model_access(a, fb, ff, eh);
      if (fb) pulse_flush();
      do_read(a, dl, ff, 0, 1'b0, saw, d);
      check("rand_hit", 32'(!saw), 32'(eh));
      check("rand_data", 32'(d), 32'(mem[a]));
    end

`ifdef FETCH_CACHE_STATS_EN
    check("stat_hits", 32'(hit_count), 32'(m_hits));
    check("stat_misses", 32'(miss_count), 32'(m_misses));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
